// File: rtl/tmds_link_ctrl.sv
// tmds_link_ctrl: pixel-domain TMDS transmit sequencer (lock qualify, serializer reset, preamble, video); optional drop counter via TMDS_LINK_DROP_CNT_EN
module tmds_link_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int IDLE_CYCLES = 64,
    parameter int LOCK_FILT   = 8
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       clk_lock,
    input  logic       de_in,
    output logic       ser_rst,
    output logic       oe,
    output logic       force_ctrl,
    output logic       link_up,
    output logic [1:0] state,
    output logic [7:0] drop_cnt
);
    localparam int SEQ_MAX = (RST_CYCLES > IDLE_CYCLES) ? RST_CYCLES : IDLE_CYCLES;
    localparam int SW = $clog2(SEQ_MAX + 1);
    localparam int LW = $clog2(LOCK_FILT + 1);

    typedef enum logic [1:0] {DOWN = 2'd0, RST = 2'd1, PREAMBLE = 2'd2, UP = 2'd3} state_t;

    state_t cur, nxt;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] seq, seq_nxt;
    logic lock_ok;

    assign lock_ok = lock_cnt == LW'(LOCK_FILT);

    // count consecutive locked samples, saturating once lock is qualified
    always_ff @(posedge clk_pix) begin
        if (rst_pix || !clk_lock) lock_cnt <= '0;
        else if (!lock_ok) lock_cnt <= lock_cnt + 1'b1;
    end

    // state and sequence counter registers
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cur <= DOWN;
            seq <= '0;
        end else begin
            cur <= nxt;
            seq <= seq_nxt;
        end
    end

    // next state: lock loss overrides everything outside DOWN
    always_comb begin
        nxt = cur;
        seq_nxt = seq;
        if (cur != DOWN && !clk_lock) nxt = DOWN;
        else begin
            case (cur)
                DOWN: if (lock_ok) begin
                    nxt = RST;
                    seq_nxt = SW'(RST_CYCLES - 1);
                end
                RST: if (seq != '0) seq_nxt = seq - 1'b1;
                     else begin
                         nxt = PREAMBLE;
                         seq_nxt = SW'(IDLE_CYCLES - 1);
                     end
                PREAMBLE: if (seq != '0) seq_nxt = seq - 1'b1;
                          else if (!de_in) nxt = UP;
                default: ;
            endcase
        end
    end

    assign state      = cur;
    assign ser_rst    = cur == DOWN || cur == RST;
    assign oe         = cur == PREAMBLE || cur == UP;
    assign force_ctrl = cur != UP;
    assign link_up    = cur == UP;

`ifdef TMDS_LINK_DROP_CNT_EN
    // count lock-loss events that tear down an active sequence, saturating
    always_ff @(posedge clk_pix) begin
        if (rst_pix) drop_cnt <= '0;
        else if (cur != DOWN && !clk_lock && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_tmds_link_ctrl.sv
// tb_tmds_link_ctrl: vector table, directed corner sequences and random stimulus against an elapsed-time reference model
module tb_tmds_link_ctrl;
    localparam int RC = 4;
    localparam int IC = 8;
    localparam int LF = 3;

    logic clk_pix = 0;
    logic rst_pix = 1, clk_lock = 0, de_in = 0;
    logic ser_rst, oe, force_ctrl, link_up;
    logic [1:0] state;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    int m_state = 0;
    int m_run = 0;
    int m_time = 0;
    int m_drops = 0;

    typedef struct {
        int   reps;
        logic r;
        logic l;
        logic d;
        int   exp_state;
    } vec_t;
    vec_t vecs[$];

    tmds_link_ctrl #(.RST_CYCLES(RC), .IDLE_CYCLES(IC), .LOCK_FILT(LF)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .clk_lock(clk_lock), .de_in(de_in),
        .ser_rst(ser_rst), .oe(oe), .force_ctrl(force_ctrl), .link_up(link_up),
        .state(state), .drop_cnt(drop_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_drop();
`ifdef TMDS_LINK_DROP_CNT_EN
        return m_drops > 255 ? 255 : m_drops;
`else
        return 0;
`endif
    endfunction

    // reference: state advances by elapsed cycles in state and consecutive-lock run length
    task automatic model_edge(input logic r, input logic l, input logic d);
        if (r) begin
            m_state = 0; m_run = 0; m_time = 0; m_drops = 0;
            return;
        end
        if (m_state == 0) begin
            if (m_run >= LF) begin m_state = 1; m_time = 0; end
        end else if (!l) begin
            m_state = 0; m_drops++;
        end else if (m_state == 1) begin
            m_time++;
            if (m_time == RC) begin m_state = 2; m_time = 0; end
        end else if (m_state == 2) begin
            m_time++;
            if (m_time >= IC && !d) m_state = 3;
        end
        m_run = l ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
    endtask

    task automatic step(input logic r, input logic l, input logic d);
        rst_pix = r; clk_lock = l; de_in = d;
        @(posedge clk_pix);
        model_edge(r, l, d);
        #1;
        chk("state", int'(state), m_state);
        chk("ser_rst", int'(ser_rst), int'(m_state <= 1));
        chk("oe", int'(oe), int'(m_state >= 2));
        chk("force_ctrl", int'(force_ctrl), int'(m_state != 3));
        chk("link_up", int'(link_up), int'(m_state == 3));
        chk("drop_cnt", int'(drop_cnt), exp_drop());
    endtask

    initial begin
        // bring-up, then DE alignment at the preamble boundary
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{7, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{15, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{5, 1'b0, 1'b1, 1'b1, 2});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 3});

        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_drop", int'(drop_cnt), 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) step(vecs[i].r, vecs[i].l, vecs[i].d);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
        end

        // one-cycle lock glitch in UP, then relock
        step(0, 0, 0);
        chk("glitch_state", int'(state), 0);
        chk("glitch_oe", int'(oe), 0);
`ifdef TMDS_LINK_DROP_CNT_EN
        chk("glitch_drop", int'(drop_cnt), 1);
`else
        chk("glitch_drop", int'(drop_cnt), 0);
`endif
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        chk("relock_wait", int'(state), 0);
        step(0, 1, 0);
        chk("relock_rst", int'(state), 1);

        // lock filter rejects short lock bursts
        step(1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0);
            step(0, 1, 0);
            step(0, 0, 0);
        end
        chk("filt_state", int'(state), 0);
        chk("filt_drop", int'(drop_cnt), 0);

        // reset mid-preamble restarts from qualification
        for (int k = 0; k < 10; k++) step(0, 1, 0);
        chk("pre_before_rst", int'(state), 2);
        step(1, 1, 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_drop", int'(drop_cnt), 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        chk("midrst_requal", int'(state), 0);
        step(0, 1, 0);
        chk("midrst_rst", int'(state), 1);

        // 300 lock-loss events from UP
        step(1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 100 && state != 2'd3; k++) step(0, 1, 0);
            chk("reach_up", int'(state), 3);
            step(0, 0, 0);
        end
`ifdef TMDS_LINK_DROP_CNT_EN
        chk("sat_drop", int'(drop_cnt), 255);
`else
        chk("sat_drop", int'(drop_cnt), 0);
`endif

        // randomized stimulus against the model
        step(1, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0, $urandom_range(0, 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
